// File: rtl/at45_pkg.sv
// Opcodes, status-bit position and FSM encoding shared by the AT45 read sequencer.
package at45_pkg;

    localparam logic [7:0] OP_STATUS    = 8'hD7;
    localparam logic [7:0] OP_CONT_READ = 8'h03;
    localparam logic [7:0] DUMMY        = 8'h00;
    localparam int         RDY_BIT      = 7;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ST_CMD = 4'd1,
        S_ST_RD  = 4'd2,
        S_CMD    = 4'd3,
        S_A2     = 4'd4,
        S_A1     = 4'd5,
        S_A0     = 4'd6,
        S_DATA   = 4'd7,
        S_DONE   = 4'd8
    } state_t;

endpackage

// File: rtl/at45_read_sequencer.sv
// AT45DBxx continuous-array-read sequencer: polls status until RDY, then sends 0x03 + address and streams N bytes.
// Rd_Valid lags SPI_Done_Sig by one clock; each engine byte is held until SPI_Done_Sig. AT45_POLL_TIMEOUT_EN adds a poll abort.
module at45_read_sequencer
    import at45_pkg::*;
#(
    parameter int          LEN_W     = 10,
    parameter logic [15:0] MAX_POLLS = 16'd50000
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             Rd_Start_Sig,
    input  logic [23:0]      Rd_Addr,
    input  logic [LEN_W-1:0] Rd_Len,
    output logic             Busy,
    output logic [7:0]       Rd_Data,
    output logic             Rd_Valid,
    output logic             Rd_Done_Sig,
    output logic             Rd_Err,
    output logic             SPI_Start_Sig,
    output logic [8:0]       SPI_Data,
    input  logic             SPI_Done_Sig,
    input  logic [7:0]       SPI_Rdata
);

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    if (MAX_POLLS == 16'd0) begin : g_bad_max_polls
        $error("MAX_POLLS must be nonzero");
    end

    state_t           state_q, state_d;
    logic [23:0]      addr_q, addr_d;
    logic [LEN_W-1:0] remain_q, remain_d;
    logic             busy_q, busy_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_done_q, rd_done_d;
    logic             spi_start_q, spi_start_d;
    logic [8:0]       spi_data_q, spi_data_d;
    logic [8:0]       tx_byte;
    logic             byte_done;

`ifdef AT45_POLL_TIMEOUT_EN
    logic [15:0] poll_q, poll_d;
    logic [15:0] poll_inc;
    logic        err_q, err_d;
`endif

    assign byte_done = spi_start_q & SPI_Done_Sig;

    always_comb begin
        tx_byte = 9'h000;
        case (state_q)
            S_ST_CMD: tx_byte = {1'b0, OP_STATUS};
            S_ST_RD:  tx_byte = {1'b1, DUMMY};
            S_CMD:    tx_byte = {1'b0, OP_CONT_READ};
            S_A2:     tx_byte = {1'b0, addr_q[23:16]};
            S_A1:     tx_byte = {1'b0, addr_q[15:8]};
            S_A0:     tx_byte = {1'b0, addr_q[7:0]};
            S_DATA:   tx_byte = {(remain_q == LEN_ONE), DUMMY};
            default:  tx_byte = 9'h000;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        busy_d      = busy_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        rd_done_d   = 1'b0;
        spi_start_d = spi_start_q;
        spi_data_d  = spi_data_q;
`ifdef AT45_POLL_TIMEOUT_EN
        poll_d   = poll_q;
        poll_inc = poll_q + 16'd1;
        err_d    = err_q;
`endif

        // Every byte-sending state: raise the request once, drop it on completion.
        if (state_q != S_IDLE && state_q != S_DONE) begin
            if (!spi_start_q) begin
                spi_start_d = 1'b1;
                spi_data_d  = tx_byte;
            end else if (SPI_Done_Sig) begin
                spi_start_d = 1'b0;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (Rd_Start_Sig) begin
                    addr_d   = Rd_Addr;
                    remain_d = Rd_Len;
                    busy_d   = 1'b1;
                    state_d  = (Rd_Len == '0) ? S_DONE : S_ST_CMD;
`ifdef AT45_POLL_TIMEOUT_EN
                    poll_d = 16'd0;
                    err_d  = 1'b0;
`endif
                end
            end
            S_ST_CMD: if (byte_done) state_d = S_ST_RD;
            S_ST_RD: begin
                if (byte_done) begin
                    if (SPI_Rdata[RDY_BIT]) begin
                        state_d = S_CMD;
                    end else begin
`ifdef AT45_POLL_TIMEOUT_EN
                        poll_d  = poll_inc;
                        state_d = (poll_inc == MAX_POLLS) ? S_DONE : S_ST_CMD;
`else
                        state_d = S_ST_CMD;
`endif
                    end
                end
            end
            S_CMD: if (byte_done) state_d = S_A2;
            S_A2:  if (byte_done) state_d = S_A1;
            S_A1:  if (byte_done) state_d = S_A0;
            S_A0:  if (byte_done) state_d = S_DATA;
            S_DATA: begin
                if (byte_done) begin
                    rd_data_d  = SPI_Rdata;
                    rd_valid_d = 1'b1;
                    remain_d   = remain_q - LEN_ONE;
                    if (remain_q == LEN_ONE) state_d = S_DONE;
                end
            end
            S_DONE: begin
                rd_done_d = 1'b1;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
`ifdef AT45_POLL_TIMEOUT_EN
                // Only a timeout leaves the poll count at the limit.
                err_d = (poll_q == MAX_POLLS);
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= S_IDLE;
            addr_q      <= 24'h000000;
            remain_q    <= '0;
            busy_q      <= 1'b0;
            rd_data_q   <= 8'h00;
            rd_valid_q  <= 1'b0;
            rd_done_q   <= 1'b0;
            spi_start_q <= 1'b0;
            spi_data_q  <= 9'h000;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            busy_q      <= busy_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_done_q   <= rd_done_d;
            spi_start_q <= spi_start_d;
            spi_data_q  <= spi_data_d;
        end
    end

`ifdef AT45_POLL_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            poll_q <= 16'd0;
            err_q  <= 1'b0;
        end else begin
            poll_q <= poll_d;
            err_q  <= err_d;
        end
    end
    assign Rd_Err = err_q;
`else
    assign Rd_Err = 1'b0;
`endif

    assign Busy          = busy_q;
    assign Rd_Data       = rd_data_q;
    assign Rd_Valid      = rd_valid_q;
    assign Rd_Done_Sig   = rd_done_q;
    assign SPI_Start_Sig = spi_start_q;
    assign SPI_Data      = spi_data_q;

endmodule

// File: tb/tb_at45_read_sequencer.sv
// Bench for at45_read_sequencer: byte-level engine model plus scoreboard queues fed by a request-level reference model.
module tb_at45_read_sequencer;

    localparam int          LEN_W        = 10;
    localparam logic [15:0] TB_MAX_POLLS = 16'd3;

    logic             CLK = 1'b0;
    logic             RSTn = 1'b0;
    logic             Rd_Start_Sig = 1'b0;
    logic [23:0]      Rd_Addr = '0;
    logic [LEN_W-1:0] Rd_Len = '0;
    logic             Busy;
    logic [7:0]       Rd_Data;
    logic             Rd_Valid;
    logic             Rd_Done_Sig;
    logic             Rd_Err;
    logic             SPI_Start_Sig;
    logic [8:0]       SPI_Data;
    logic             SPI_Done_Sig = 1'b0;
    logic [7:0]       SPI_Rdata = '0;

    at45_read_sequencer #(.LEN_W(LEN_W), .MAX_POLLS(TB_MAX_POLLS)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .Rd_Start_Sig(Rd_Start_Sig), .Rd_Addr(Rd_Addr), .Rd_Len(Rd_Len),
        .Busy(Busy), .Rd_Data(Rd_Data), .Rd_Valid(Rd_Valid),
        .Rd_Done_Sig(Rd_Done_Sig), .Rd_Err(Rd_Err),
        .SPI_Start_Sig(SPI_Start_Sig), .SPI_Data(SPI_Data),
        .SPI_Done_Sig(SPI_Done_Sig), .SPI_Rdata(SPI_Rdata)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit err;
        int cyc;
    } done_t;

    logic [8:0] exp_spi_q[$];
    logic [7:0] rsp_q[$];
    logic [7:0] exp_dat_q[$];
    done_t      exp_done_q[$];

    int n_checks   = 0;
    int n_pass     = 0;
    int done_seen  = 0;
    int valid_seen = 0;
    int eng_bytes  = 0;
    int done_cyc   = -10;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_byte(input logic [8:0] b, input logic [7:0] r);
        exp_spi_q.push_back(b);
        rsp_q.push_back(r);
    endtask

    // Reference model: the full byte sequence a request should produce on the engine interface.
    task automatic model(input logic [23:0] addr, input int len, input int nbad,
                         input bit directed, input int start_cyc);
        int         polls;
        bit         err;
        logic [7:0] st;
        logic [7:0] dat;
        done_t      d;
        polls = 0;
        err   = 1'b0;
        if (len == 0) begin
            d.err = 1'b0;
            d.cyc = start_cyc + 2;
            exp_done_q.push_back(d);
            return;
        end
        forever begin
            push_byte(9'h0D7, 8'($urandom));
            if (polls < nbad) st = directed ? 8'h00 : (8'($urandom) & 8'h7F);
            else              st = directed ? 8'h80 : (8'($urandom) | 8'h80);
            push_byte(9'h100, st);
            if (st[7]) break;
            polls++;
`ifdef AT45_POLL_TIMEOUT_EN
            if (polls == int'(TB_MAX_POLLS)) begin
                err = 1'b1;
                break;
            end
`endif
        end
        if (!err) begin
            push_byte(9'h003, 8'($urandom));
            push_byte({1'b0, addr[23:16]}, 8'($urandom));
            push_byte({1'b0, addr[15:8]},  8'($urandom));
            push_byte({1'b0, addr[7:0]},   8'($urandom));
            for (int i = 0; i < len; i++) begin
                dat = directed ? 8'(17 * (i + 1)) : 8'($urandom);
                push_byte({(i == len - 1), 8'h00}, dat);
                exp_dat_q.push_back(dat);
            end
        end
        d.err = err;
        d.cyc = -1;
        exp_done_q.push_back(d);
    endtask

    // Engine model and SPI-side monitor.
    initial begin
        logic [8:0] cur_dat;
        logic [7:0] cur_rsp;
        int         wait_cnt;
        bit         serving;
        serving  = 1'b0;
        wait_cnt = 0;
        cur_dat  = '0;
        cur_rsp  = '0;
        forever begin
            @(negedge CLK);
            if (!RSTn) begin
                serving      = 1'b0;
                SPI_Done_Sig = 1'b0;
            end else if (SPI_Done_Sig) begin
                SPI_Done_Sig = 1'b0;
                check_eq("spi_start_drop", 32'(SPI_Start_Sig), 32'd0);
            end else if (serving) begin
                check_eq("spi_data_stable", 32'(SPI_Data), 32'(cur_dat));
                if (wait_cnt == 0) begin
                    SPI_Done_Sig = 1'b1;
                    SPI_Rdata    = cur_rsp;
                    serving      = 1'b0;
                    done_cyc     = cyc;
                end else begin
                    wait_cnt--;
                end
            end else if (SPI_Start_Sig) begin
                eng_bytes++;
                cur_dat = SPI_Data;
                check_eq("spi_byte_expected", 32'(exp_spi_q.size() != 0), 32'd1);
                if (exp_spi_q.size() != 0) check_eq("spi_byte", 32'(SPI_Data), 32'(exp_spi_q.pop_front()));
                cur_rsp  = (rsp_q.size() != 0) ? rsp_q.pop_front() : 8'($urandom);
                serving  = 1'b1;
                wait_cnt = $urandom_range(0, 2);
            end
        end
    end

    // Host-side monitor.
    initial begin
        done_t e;
        forever begin
            @(negedge CLK);
            if (RSTn && Rd_Valid) begin
                valid_seen++;
                check_eq("rd_valid_latency", 32'(cyc), 32'(done_cyc + 1));
                check_eq("rd_valid_expected", 32'(exp_dat_q.size() != 0), 32'd1);
                if (exp_dat_q.size() != 0) check_eq("rd_data", 32'(Rd_Data), 32'(exp_dat_q.pop_front()));
            end
            if (RSTn && Rd_Done_Sig) begin
                done_seen++;
                check_eq("rd_done_expected", 32'(exp_done_q.size() != 0), 32'd1);
                check_eq("busy_low_at_done", 32'(Busy), 32'd0);
                if (exp_done_q.size() != 0) begin
                    e = exp_done_q.pop_front();
                    check_eq("rd_err", 32'(Rd_Err), 32'(e.err));
                    if (e.cyc >= 0) check_eq("rd_done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_seen < target && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        check_eq("request_completes", 32'(done_seen >= target), 32'd1);
    endtask

    task automatic start_req(input logic [23:0] addr, input int len, input int nbad, input bit directed);
        model(addr, len, nbad, directed, cyc);
        Rd_Addr      = addr;
        Rd_Len       = LEN_W'(len);
        Rd_Start_Sig = 1'b1;
        @(negedge CLK);
        Rd_Start_Sig = 1'b0;
        Rd_Addr      = 24'($urandom);
        Rd_Len       = LEN_W'($urandom);
        check_eq("busy_after_accept", 32'(Busy), 32'd1);
    endtask

    task automatic run_req(input logic [23:0] addr, input int len, input int nbad, input bit directed);
        int target;
        target = done_seen + 1;
        start_req(addr, len, nbad, directed);
        wait_done(target);
        repeat (2) @(negedge CLK);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_busy"},      32'(Busy),          32'd0);
        check_eq({tag, "_spi_start"}, 32'(SPI_Start_Sig), 32'd0);
        check_eq({tag, "_spi_data"},  32'(SPI_Data),      32'd0);
        check_eq({tag, "_rd_valid"},  32'(Rd_Valid),      32'd0);
        check_eq({tag, "_rd_done"},   32'(Rd_Done_Sig),   32'd0);
        check_eq({tag, "_rd_err"},    32'(Rd_Err),        32'd0);
        check_eq({tag, "_rd_data"},   32'(Rd_Data),       32'd0);
    endtask

    initial begin
        int target;
        int n;
        int nbad3;
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;

        // Idle after reset: nothing moves.
        repeat (20) @(negedge CLK);
        check_outputs_zero("reset");
        check_eq("no_spi_while_idle", 32'(eng_bytes), 32'd0);

        // Directed read of four bytes from 0x000210.
        run_req(24'h000210, 4, 0, 1'b1);

        // Device busy for several polls before RDY.
`ifdef AT45_POLL_TIMEOUT_EN
        nbad3 = 2;
`else
        nbad3 = 3;
`endif
        run_req(24'hABCDEF, 2, nbad3, 1'b1);

        // Zero-length request.
        run_req(24'h123456, 0, 0, 1'b0);

        // Second request during DATA is ignored.
        target = done_seen + 1;
        start_req(24'h0F0F0F, 6, 0, 1'b0);
        n = 0;
        while (valid_seen < 2 * (target) + 100 && n < 3000) begin
            if (Rd_Valid) break;
            @(negedge CLK);
            n++;
        end
        check_eq("data_phase_reached", 32'(n < 3000), 32'd1);
        Rd_Addr      = 24'hFFFFFF;
        Rd_Len       = LEN_W'(3);
        Rd_Start_Sig = 1'b1;
        @(negedge CLK);
        Rd_Start_Sig = 1'b0;
        wait_done(target);
        repeat (4) @(negedge CLK);
        check_eq("ignored_start_idle", 32'(Busy), 32'd0);

        // Reset while the middle address byte is outstanding.
        n = eng_bytes + 5;
        start_req(24'h445566, 4, 0, 1'b0);
        target = 0;
        while (eng_bytes < n && target < 3000) begin
            @(negedge CLK);
            target++;
        end
        check_eq("reached_a1", 32'(eng_bytes >= n), 32'd1);
        RSTn = 1'b0;
        #1;
        check_outputs_zero("midreset");
        exp_spi_q.delete();
        rsp_q.delete();
        exp_dat_q.delete();
        exp_done_q.delete();
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        repeat (2) @(negedge CLK);
        run_req(24'h445566, 3, 1, 1'b0);

`ifdef AT45_POLL_TIMEOUT_EN
        // Device never ready: abort after the poll limit, then a clean request clears Rd_Err.
        run_req(24'h000100, 4, 1000, 1'b1);
        check_eq("err_held_after_done", 32'(Rd_Err), 32'd1);
        run_req(24'h000200, 2, 0, 1'b0);
`endif

        // Random requests, first one single-byte.
        for (int i = 0; i < 10; i++) begin
            run_req(24'($urandom), (i == 0) ? 1 : $urandom_range(1, 6), $urandom_range(0, 2), 1'b0);
        end

        check_eq("spi_queue_drained",  32'(exp_spi_q.size()),  32'd0);
        check_eq("data_queue_drained", 32'(exp_dat_q.size()),  32'd0);
        check_eq("done_queue_drained", 32'(exp_done_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
